// File: rtl/debug_capture_buffer.sv
// rtl/debug_capture_buffer.sv - FIFO capture buffer for the HeMPS debug word stream
// Optional macro DEBUG_CAPTURE_TIMESTAMP_EN adds a per-word capture timestamp.
module debug_capture_buffer #(
  parameter int DEPTH       = 16,
  parameter int BUSY_MARGIN = 2,
  parameter int DROP_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable_debug,
  input  logic [31:0]              data_out_debug,
  output logic                     busy_debug,
  output logic                     log_valid,
  output logic [31:0]              log_data,
  output logic [31:0]              log_timestamp,
  input  logic                     log_ready,
  input  logic                     flush,
  input  logic                     clear_overflow,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_MARGIN = (AW+1)'(BUSY_MARGIN);

  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic [AW:0]       next_level;
  logic              next_busy;
  logic [DROP_W-1:0] drop_base;
  logic [DROP_W-1:0] next_drop_count;
  logic              next_overflow;

  always_comb begin
    full = (level == LVL_FULL);
    // Full is judged on the registered level, so a same-cycle pop cannot rescue a push.
    push = write_enable_debug & ~full & ~flush;
    drop = write_enable_debug & full & ~flush;
    pop  = log_valid & log_ready & ~flush;
    if (flush) begin
      next_level = '0;
    end else begin
      next_level = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
    next_busy = (LVL_FULL - next_level) <= LVL_MARGIN;
  end

  // Clear takes effect first, then any drop in the same cycle is counted on top of it.
  always_comb begin
    drop_base       = clear_overflow ? '0 : drop_count;
    next_overflow   = (overflow & ~clear_overflow) | drop;
    next_drop_count = drop_base;
    if (drop && (drop_base != {DROP_W{1'b1}})) begin
      next_drop_count = drop_base + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      busy_debug <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level      <= next_level;
      busy_debug <= next_busy;
      overflow   <= next_overflow;
      drop_count <= next_drop_count;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data_out_debug;
  end

  assign log_valid = (level != '0);
  // Storage is never reset; masking keeps the head word from showing X while empty.
  assign log_data  = log_valid ? mem[rd_ptr] : '0;

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
  logic [31:0] cycle_count;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) ts_mem[wr_ptr] <= cycle_count;
  end

  assign log_timestamp = log_valid ? ts_mem[rd_ptr] : '0;
`else
  assign log_timestamp = '0;
`endif

endmodule

// File: tb/tb_debug_capture_buffer.sv
// tb/tb_debug_capture_buffer.sv - randomized self-checking bench for debug_capture_buffer
module tb_debug_capture_buffer;

  localparam int DEPTH       = 16;
  localparam int BUSY_MARGIN = 2;
  localparam int DROP_W      = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              write_enable_debug = 1'b0;
  logic [31:0]       data_out_debug = '0;
  logic              busy_debug;
  logic              log_valid;
  logic [31:0]       log_data;
  logic [31:0]       log_timestamp;
  logic              log_ready = 1'b0;
  logic              flush = 1'b0;
  logic              clear_overflow = 1'b0;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic [4:0]        level;

  debug_capture_buffer #(.DEPTH(DEPTH), .BUSY_MARGIN(BUSY_MARGIN), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset),
    .write_enable_debug(write_enable_debug), .data_out_debug(data_out_debug),
    .busy_debug(busy_debug), .log_valid(log_valid), .log_data(log_data),
    .log_timestamp(log_timestamp), .log_ready(log_ready), .flush(flush),
    .clear_overflow(clear_overflow), .overflow(overflow), .drop_count(drop_count),
    .level(level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic [31:0] ts;
  } ent_t;

  ent_t        q[$];
  int          m_drops;
  logic        m_ov;
  logic        m_busy;
  logic [31:0] m_cyc;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drops = 0;
    m_ov    = 1'b0;
    m_busy  = 1'b0;
    m_cyc   = '0;
  endtask

  // Applies one clock edge worth of behaviour to the queue model.
  task automatic model_step();
    bit was_full, do_drop;
    ent_t e;
    was_full = (q.size() == DEPTH);
    do_drop  = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && log_ready) void'(q.pop_front());
      if (write_enable_debug && !was_full) begin
        e.d  = data_out_debug;
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
        e.ts = m_cyc;
`else
        e.ts = 32'd0;
`endif
        q.push_back(e);
      end
      do_drop = write_enable_debug && was_full;
    end
    if (clear_overflow) begin
      m_ov    = 1'b0;
      m_drops = 0;
    end
    if (do_drop) begin
      m_ov = 1'b1;
      if (m_drops < (1 << DROP_W) - 1) m_drops++;
    end
    m_busy = (DEPTH - q.size()) <= BUSY_MARGIN;
    m_cyc  = m_cyc + 32'd1;
  endtask

  task automatic check_all();
    check("level", 64'(level), 64'(q.size()));
    check("log_valid", 64'(log_valid), 64'(q.size() != 0));
    check("busy_debug", 64'(busy_debug), 64'(m_busy));
    check("overflow", 64'(overflow), 64'(m_ov));
    check("drop_count", 64'(drop_count), 64'(m_drops));
    if (q.size() != 0) begin
      check("log_data", 64'(log_data), 64'(q[0].d));
      check("log_timestamp", 64'(log_timestamp), 64'(q[0].ts));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_debug), 64'd0);
    check({tag, "_valid"}, 64'(log_valid), 64'd0);
    check({tag, "_data"}, 64'(log_data), 64'd0);
    check({tag, "_ts"}, 64'(log_timestamp), 64'd0);
    check({tag, "_ov"}, 64'(overflow), 64'd0);
    check({tag, "_drops"}, 64'(drop_count), 64'd0);
    check({tag, "_level"}, 64'(level), 64'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic we, input logic [31:0] d, input logic rdy,
                       input logic fl, input logic clr);
    write_enable_debug = we;
    data_out_debug     = d;
    log_ready          = rdy;
    flush              = fl;
    clear_overflow     = clr;
    tick();
  endtask

  task automatic release_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 60) == 0, $urandom_range(0, 40) == 0);
    end
  endtask

  initial begin
    model_reset();
    #3;
    check_reset_outputs("reset");
    release_reset();
    check_reset_outputs("post_release");

    drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("three_words_level", 64'(level), 64'd0);

    for (int i = 0; i < 14; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("busy_after_14", 64'(busy_debug), 64'd1);
    for (int i = 14; i < 16; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("full_level", 64'(level), 64'd16);
    check("full_no_drops", 64'(drop_count), 64'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hdead0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("drops_5", 64'(drop_count), 64'd5);
    check("ov_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", 64'(log_data), 64'h100 + 64'(i));
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 16; i++) drive(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hbad0bad0, 1'b1, 1'b0, 1'b0);
    check("push_pop_full_level", 64'(level), 64'd15);
    check("push_pop_full_drops", 64'(drop_count), 64'd6);
    drive(1'b1, 32'h5555, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h6666, 1'b0, 1'b0, 1'b1);
    check("clear_with_drop_ov", 64'(overflow), 64'd1);
    check("clear_with_drop_cnt", 64'(drop_count), 64'd1);

    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
    check("pre_flush_level", 64'(level), 64'd9);
    drive(1'b1, 32'h7777, 1'b0, 1'b1, 1'b0);
    check("flush_level", 64'(level), 64'd0);
    check("flush_valid", 64'(log_valid), 64'd0);
    check("flush_drops", 64'(drop_count), 64'd1);

    random_phase(1500);

    for (int i = 0; i < 6; i++) drive(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    release_reset();
    check_reset_outputs("async_release");

    random_phase(1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
